// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes, FSM states and command record for the ALU issue stage
package alu_pkg;

  localparam int ALU_W = 16;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR = 3'b110;
  localparam logic [OP_W-1:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [OP_W-1:0]  op;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO; head is the oldest entry, pointers wrap modulo DEPTH
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  alu_cmd_t                 push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output alu_cmd_t                 head
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - buffers ALU commands, issues one at a time with a single enable pulse, holds each result
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALU_W-1:0]       in_a,
  input  logic [ALU_W-1:0]       in_b,
  input  logic [OP_W-1:0]        in_op,
  output logic [ALU_W-1:0]       alu_a,
  output logic [ALU_W-1:0]       alu_b,
  output logic [OP_W-1:0]        alu_op,
  output logic                   alu_enable,
  input  logic [ALU_W-1:0]       alu_result,
  input  logic                   alu_zero,
  input  logic                   alu_carry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALU_W-1:0]       out_result,
  output logic                   out_zero,
  output logic                   out_carry,
  output logic [OP_W-1:0]        out_op,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int LW = $clog2(ALU_LAT + 1);

  state_t         state_q, state_d;
  logic [LW-1:0]  wait_q, wait_d;
  logic           fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic           take, load, bypass, capture;
  alu_cmd_t       head, in_cmd, next_cmd;

  assign in_cmd    = '{a: in_a, b: in_b, op: in_op};
  assign in_ready  = rst_n && !fifo_full;
  assign fifo_push = in_valid && in_ready && !bypass;
  assign next_cmd  = bypass ? in_cmd : head;
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (in_cmd),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  // An arriving command with an empty FIFO goes straight to the operand registers.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    take       = 1'b0;
    load       = 1'b0;
    bypass     = 1'b0;
    fifo_pop   = 1'b0;
    capture    = 1'b0;
    alu_enable = 1'b0;
    case (state_q)
      ST_IDLE: take = 1'b1;
      ST_ISSUE: begin
        alu_enable = 1'b1;
        wait_d     = LW'(ALU_LAT);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_d = wait_q - LW'(1);
        if (wait_q == LW'(1)) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          take    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      if (!fifo_empty) begin
        load     = 1'b1;
        fifo_pop = 1'b1;
        state_d  = ST_ISSUE;
      end else if (in_valid && in_ready) begin
        load    = 1'b1;
        bypass  = 1'b1;
        state_d = ST_ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      out_op     <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (load) begin
        alu_a  <= next_cmd.a;
        alu_b  <= next_cmd.b;
        alu_op <= next_cmd.op;
      end
      if (capture) begin
        out_result <= alu_result;
        out_zero   <= alu_zero;
        out_carry  <= alu_carry;
        out_op     <= alu_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a one-cycle ALU model
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] res;
    logic        z;
    logic        c;
  } vec_t;

  logic        clk, rst_n, in_valid, in_ready, alu_enable, alu_zero, alu_carry;
  logic        out_valid, out_ready, out_zero, out_carry, busy;
  logic [15:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
  logic [2:0]  in_op, alu_op, out_op;
  logic [2:0]  fifo_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  vec_t sb[$];
  int   hs[$];
  vec_t mon_e;
  vec_t vecs[11];
  vec_t bp[5];
  vec_t rs[5];

  alu_issue_ctrl #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry), .out_op(out_op),
    .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    logic [16:0] w;
    logic [15:0] m;
    case (op)
      OP_ADD: w = {1'b0, a} + {1'b0, b};
      OP_SUB: w = {1'b0, a} - {1'b0, b};
      OP_AND: w = {1'b0, a & b};
      OP_OR:  w = {1'b0, a | b};
      OP_XOR: w = {1'b0, a ^ b};
      OP_SHL: w = {1'b0, a} << b[3:0];
      OP_SHR: w = {1'b0, a >> b[3:0]};
      default: begin
        m = a * b;
        w = {1'b0, m};
      end
    endcase
    return {(w[15:0] == 16'd0), w[16], w[15:0]};
  endfunction

  always @(posedge clk) begin
    if (alu_enable) {alu_zero, alu_carry, alu_result} <= alu_f(alu_a, alu_b, alu_op);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h with nothing expected (cycle %0d)", out_result, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("out_result", out_result, mon_e.res);
        chk("out_zero", out_zero, mon_e.z);
        chk("out_carry", out_carry, mon_e.c);
        chk("out_op", out_op, mon_e.op);
        hs.push_back(cyc);
      end
    end
  end

  task automatic send(input vec_t r);
    int t;
    in_valid = 1'b1;
    in_a = r.a;
    in_b = r.b;
    in_op = r.op;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept", in_ready, 1'b1);
    if (in_ready) sb.push_back(r);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    alu_result = '0; alu_zero = 1'b0; alu_carry = 1'b0;

    vecs[0]  = '{16'd1000,  16'd500,   OP_ADD, 16'd1500,  1'b0, 1'b0};
    vecs[1]  = '{16'd65000, 16'd1000,  OP_ADD, 16'd464,   1'b0, 1'b1};
    vecs[2]  = '{16'd500,   16'd500,   OP_SUB, 16'd0,     1'b1, 1'b0};
    vecs[3]  = '{16'd1,     16'd2,     OP_SUB, 16'hFFFF,  1'b0, 1'b1};
    vecs[4]  = '{16'hF0F0,  16'h0FF0,  OP_AND, 16'h00F0,  1'b0, 1'b0};
    vecs[5]  = '{16'hF000,  16'h000F,  OP_OR,  16'hF00F,  1'b0, 1'b0};
    vecs[6]  = '{16'hFFFF,  16'hAAAA,  OP_XOR, 16'h5555,  1'b0, 1'b0};
    vecs[7]  = '{16'h8001,  16'd1,     OP_SHL, 16'h0002,  1'b0, 1'b1};
    vecs[8]  = '{16'h8000,  16'd3,     OP_SHR, 16'h1000,  1'b0, 1'b0};
    vecs[9]  = '{16'd300,   16'd300,   OP_MUL, 16'd24464, 1'b0, 1'b0};
    vecs[10] = '{16'h1234,  16'h1234,  OP_XOR, 16'h0000,  1'b1, 1'b0};

    bp[0] = '{16'd100,  16'd200,  OP_MUL, 16'd20000, 1'b0, 1'b0};
    bp[1] = '{16'hFFFF, 16'hAAAA, OP_XOR, 16'h5555,  1'b0, 1'b0};
    bp[2] = '{16'd1,    16'd1,    OP_ADD, 16'd2,     1'b0, 1'b0};
    bp[3] = '{16'd2,    16'd2,    OP_ADD, 16'd4,     1'b0, 1'b0};
    bp[4] = '{16'd3,    16'd3,    OP_ADD, 16'd6,     1'b0, 1'b0};

    for (int i = 0; i < 5; i++) rs[i] = '{16'd10, 16'(i + 1), OP_ADD, 16'(11 + i), 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_enable", alu_enable, 1'b0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready_low", in_ready, 1'b0);
    chk("rst_operands", {alu_a, alu_b, alu_op}, 35'd0);
    chk("rst_out_regs", {out_result, out_zero, out_carry, out_op}, 21'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    @(posedge clk); #2;

    // Single commands into an idle stage: enable at A+1, result at A+3.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i]);
      @(negedge clk);
      chk("issue_enable", alu_enable, 1'b1);
      chk("issue_operands", {alu_a, alu_b, alu_op}, {vecs[i].a, vecs[i].b, vecs[i].op});
      @(negedge clk);
      chk("wait_enable_low", alu_enable, 1'b0);
      chk("wait_out_valid_low", out_valid, 1'b0);
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1'b1);
      @(negedge clk);
      chk("after_hs_out_valid", out_valid, 1'b0);
      chk("after_hs_busy", busy, 1'b0);
      @(posedge clk); #2;
    end

    // Back-pressure: fill the FIFO, then release and measure spacing.
    out_ready = 1'b0;
    hs.delete();
    for (int i = 0; i < 5; i++) send(bp[i]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 1'b0);
      chk("full_count", fifo_count, 3'd4);
      chk("hold_stable", {out_valid, out_result, out_op}, {1'b1, 16'd20000, OP_MUL});
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("bp_drained", {sb.size() == 0, busy}, 2'b10);
    chk("bp_result_count", hs.size(), 5);
    for (int i = 1; i < 5; i++) begin
      if (i < hs.size()) chk("bp_spacing", hs[i] - hs[i-1], 3);
    end

    // Quiet idle: no enable pulses, operands keep the last issued command.
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("idle_quiet", {alu_enable, busy, out_valid, alu_op, alu_a, alu_b},
          {1'b0, 1'b0, 1'b0, OP_ADD, 16'd3, 16'd3});
    end

    // Reset during WAIT with three commands still queued.
    @(posedge clk); #2;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(rs[i]);
    out_ready = 1'b1;
    @(negedge clk);
    chk("pre_rst_hold", {out_valid, fifo_count}, {1'b1, 3'd4});
    @(posedge clk); #2;
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_issue", {alu_enable, fifo_count}, {1'b1, 3'd3});
    @(posedge clk); #2;
    @(negedge clk);
    chk("pre_rst_wait", {alu_enable, out_valid, busy, fifo_count}, {1'b0, 1'b0, 1'b1, 3'd3});
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_state", {out_valid, alu_enable, busy, fifo_count}, 6'd0);
    chk("mid_rst_regs", {out_result, out_op, alu_a}, 35'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", {out_valid, alu_enable, in_ready}, 3'b001);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
